// File: rtl/drac_pkg.sv
// drac_pkg: shared types and constants for the L2 refill arbiter slice.
//   - Fixed acquire-field constants (block GET) that the enclosing top level
//     drives onto the L2 acquire channel alongside this block's outputs.
//   - Reference acquire/grant record layouts at the default widths.
//   - refill_state_t: per-client refill tracker state.
package drac_pkg;

  localparam logic        ACQ_BUILTIN          = 1'b1;
  localparam logic [2:0]  ACQ_A_TYPE_GET_BLOCK = 3'b001;
  localparam logic [16:0] ACQ_UNION_DEFAULT    = 17'b00000000111000001;

  localparam int unsigned DRAC_ADDR_W = 26;
  localparam int unsigned DRAC_ID_W   = 3;
  localparam int unsigned DRAC_DATA_W = 128;
  localparam int unsigned DRAC_BEAT_W = 2;

  typedef struct packed {
    logic [DRAC_ADDR_W-1:0] addr_block;
    logic [DRAC_ID_W-1:0]   xact_id;
  } mem_acquire_t;

  typedef struct packed {
    logic [DRAC_DATA_W-1:0] data;
    logic [DRAC_BEAT_W-1:0] beat;
    logic [DRAC_ID_W-1:0]   xact_id;
    logic                   valid;
  } mem_grant_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    WAIT = 2'd2
  } refill_state_t;

endpackage

// File: rtl/refill_client_tracker.sv
// refill_client_tracker: one refill client's FSM, beat counter and kill flag.
//   accept_i     request accepted by the arbiter (IDLE -> ACQ)
//   acq_hs_i     this client's acquire handshook on L2 (ACQ -> WAIT)
//   kill_i       abandon the outstanding refill
//   grant_hit_i  grant beat addressed to this client (only asserted in WAIT)
//   grant_beat_i beat index of that grant
//   busy_o       state != IDLE
//   wait_o       state == WAIT
//   deliver_o    beat is forwarded to the client
//   last_o       delivered beat is the final one
//   beat_err_o   beat index differs from the expected count
module refill_client_tracker
  import drac_pkg::*;
#(
  parameter int unsigned BEATS  = 4,
  parameter int unsigned BEAT_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              accept_i,
  input  logic              acq_hs_i,
  input  logic              kill_i,
  input  logic              grant_hit_i,
  input  logic [BEAT_W-1:0] grant_beat_i,
  output logic              busy_o,
  output logic              wait_o,
  output logic              deliver_o,
  output logic              last_o,
  output logic              beat_err_o
);

  refill_state_t     state_q, state_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic              killed_q, killed_d;
  logic              is_last;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      killed_q <= killed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    killed_d   = killed_q;
    deliver_o  = 1'b0;
    last_o     = 1'b0;
    beat_err_o = 1'b0;
    is_last    = (grant_beat_i == BEAT_W'(BEATS - 1));
    case (state_q)
      IDLE: begin
        if (accept_i) begin
          state_d  = ACQ;
          cnt_d    = '0;
          killed_d = 1'b0;
        end
      end
      ACQ: begin
        if (kill_i) killed_d = 1'b1;
        if (acq_hs_i) state_d = WAIT;
      end
      WAIT: begin
        if (kill_i) killed_d = 1'b1;
        if (grant_hit_i) begin
          // Out-of-order beats are still delivered; counter resyncs to the beat seen.
          beat_err_o = (grant_beat_i != cnt_q);
          cnt_d      = grant_beat_i + BEAT_W'(1);
          // A kill arriving with a beat suppresses that beat too.
          deliver_o  = !(killed_q || kill_i);
          last_o     = deliver_o && is_last;
          if (is_last) begin
            state_d  = IDLE;
            killed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);
  assign wait_o = (state_q == WAIT);

endmodule

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: shares one L2 acquire/grant port among NUM_CLIENTS
// block-refill clients (0 = icache, 1 = dcache).
//   req_*        per-client block-read requests; req_ready_o one-hot accept
//   kill_i       per-client abandon of the outstanding refill
//   acquire_*    registered L2 acquire, tagged with the client index as id
//   grant_*      L2 grant beats, routed back by xact id
//   resp_*       registered per-client beat delivery (data/beat shared)
//   busy_o       per-client refill outstanding
//   err_o        sticky protocol error (unexpected id or out-of-order beat)
module mem_refill_arbiter
  import drac_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned BEATS       = 4,
  parameter int unsigned ADDR_W      = 26,
  parameter int unsigned ID_W        = 3,
  localparam int unsigned BEAT_W     = $clog2(BEATS)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CLIENTS-1:0]        req_valid_i,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_paddr_i,
  output logic [NUM_CLIENTS-1:0]        req_ready_o,
  input  logic [NUM_CLIENTS-1:0]        kill_i,
  output logic                          acquire_valid_o,
  input  logic                          acquire_ready_i,
  output logic [ADDR_W-1:0]             acquire_addr_block_o,
  output logic [ID_W-1:0]               acquire_xact_id_o,
  input  logic                          grant_valid_i,
  input  logic [DATA_W-1:0]             grant_data_i,
  input  logic [BEAT_W-1:0]             grant_beat_i,
  input  logic [ID_W-1:0]               grant_xact_id_i,
  output logic                          grant_ready_o,
  output logic [NUM_CLIENTS-1:0]        resp_valid_o,
  output logic [DATA_W-1:0]             resp_data_o,
  output logic [BEAT_W-1:0]             resp_beat_o,
  output logic [NUM_CLIENTS-1:0]        resp_last_o,
  output logic [NUM_CLIENTS-1:0]        busy_o,
  output logic                          err_o
);

  localparam int unsigned RR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  logic [RR_W-1:0]        rr_q, rr_d;
  logic                   acq_valid_q;
  logic [ADDR_W-1:0]      acq_addr_q, acq_addr_d;
  logic [ID_W-1:0]        acq_id_q;
  logic [NUM_CLIENTS-1:0] resp_valid_q, resp_last_q;
  logic [DATA_W-1:0]      resp_data_q;
  logic [BEAT_W-1:0]      resp_beat_q;
  logic                   err_q, err_d;

  logic [NUM_CLIENTS-1:0] busy, in_wait, accept, acq_hs, hit, deliver, last, beat_err;
  logic                   acq_free, any_accept;
  int unsigned            arb_idx, win_idx;

  // The acquire register can take a new request when empty or draining now.
  assign acq_free = !acq_valid_q || acquire_ready_i;

  always_comb begin
    accept     = '0;
    any_accept = 1'b0;
    arb_idx    = 0;
    win_idx    = 0;
    rr_d       = rr_q;
    if (acq_free) begin
      for (int unsigned off = 0; off < NUM_CLIENTS; off++) begin
        arb_idx = (32'(rr_q) + off) % NUM_CLIENTS;
        if (!any_accept && !busy[arb_idx] && req_valid_i[arb_idx]) begin
          any_accept       = 1'b1;
          win_idx          = arb_idx;
          accept[arb_idx]  = 1'b1;
        end
      end
    end
    if (any_accept) rr_d = RR_W'((win_idx + 1) % NUM_CLIENTS);
    acq_addr_d = req_paddr_i[win_idx*ADDR_W +: ADDR_W];
  end

  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_client
    assign acq_hs[i] = acq_valid_q && acquire_ready_i && (acq_id_q == ID_W'(i));
    assign hit[i]    = grant_valid_i && (grant_xact_id_i == ID_W'(i)) && in_wait[i];

    refill_client_tracker #(
      .BEATS  (BEATS),
      .BEAT_W (BEAT_W)
    ) u_trk (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .accept_i     (accept[i]),
      .acq_hs_i     (acq_hs[i]),
      .kill_i       (kill_i[i]),
      .grant_hit_i  (hit[i]),
      .grant_beat_i (grant_beat_i),
      .busy_o       (busy[i]),
      .wait_o       (in_wait[i]),
      .deliver_o    (deliver[i]),
      .last_o       (last[i]),
      .beat_err_o   (beat_err[i])
    );
  end

  // A beat nobody in WAIT owns (including out-of-range ids) is dropped and flagged.
  assign err_d = err_q || (grant_valid_i && (hit == '0)) || (|beat_err);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q         <= '0;
      acq_valid_q  <= 1'b0;
      acq_addr_q   <= '0;
      acq_id_q     <= '0;
      resp_valid_q <= '0;
      resp_last_q  <= '0;
      resp_data_q  <= '0;
      resp_beat_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      resp_valid_q <= deliver;
      resp_last_q  <= last;
      err_q        <= err_d;
      if (any_accept) begin
        acq_valid_q <= 1'b1;
        acq_addr_q  <= acq_addr_d;
        acq_id_q    <= ID_W'(win_idx);
      end else if (acquire_ready_i) begin
        acq_valid_q <= 1'b0;
      end
      if (grant_valid_i) begin
        resp_data_q <= grant_data_i;
        resp_beat_q <= grant_beat_i;
      end
    end
  end

  assign req_ready_o          = accept;
  assign acquire_valid_o      = acq_valid_q;
  assign acquire_addr_block_o = acq_addr_q;
  assign acquire_xact_id_o    = acq_id_q;
  assign grant_ready_o        = 1'b1;
  assign resp_valid_o         = resp_valid_q;
  assign resp_data_o          = resp_data_q;
  assign resp_beat_o          = resp_beat_q;
  assign resp_last_o          = resp_last_q;
  assign busy_o               = busy;
  assign err_o                = err_q;

endmodule
